tx_burst_arbiter: RTL and testbench

- Shares one downstream valid/ready sink between NSRC burst transmitters of the tx2 type.
- Each transmitter drives data plus valid and waits on its own ready.
- The arbiter grants one source at a time, round-robin, at burst granularity, and forwards beats through a one-entry output register.
- Sits between the burst generators and the single consumer. Provides burst-done and abort status to the control logic.

---
 rtl/tx_pkg.sv | 18 +
 rtl/rr_pick.sv | 29 ++
 rtl/tx_burst_arbiter.sv | 147 ++++++++++++++
 tb/tb_tx_burst_arbiter.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tx_pkg.sv
// Shared types and helpers for the tx burst path.
// Holds the arbiter state enum, default burst sizing and the counter-width helper.
package tx_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } tx_state_e;

  localparam int TX_BURST_LEN = 7;
  localparam int TX_TIMEOUT   = 16;

  // Bits needed to index n items; never less than one bit.
  function automatic int tx_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Round-robin picker: first asserted request at or after ptr, wrapping modulo N.
// Purely combinational so any scheduler can register the result as it needs.
module rr_pick #(
  parameter int N  = 2,
  parameter int IW = 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [IW-1:0] winner,
  output logic          found
);

  logic [IW-1:0] idx;

  // Walk from the farthest candidate back to ptr so the closest hit is written last.
  always_comb begin
    winner = '0;
    found  = 1'b0;
    idx    = '0;
    for (int k = N - 1; k >= 0; k--) begin
      idx = IW'((int'(ptr) + k) % N);
      if (req[idx]) begin
        winner = idx;
        found  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/tx_burst_arbiter.sv
// Burst-granular round-robin arbiter sharing one valid/ready sink between NSRC sources.
// Beats pass through a one-entry output register; burst end/abort reported as pulses.
//   state | meaning
//   IDLE  | no grant; one-cycle arbitration scan from rr_ptr
//   BURST | grant_id owns the sink until BURST_LEN beats or an idle timeout
module tx_burst_arbiter
  import tx_pkg::*;
#(
  parameter int NSRC      = 2,
  parameter int DW        = 32,
  parameter int BURST_LEN = TX_BURST_LEN,
  parameter int TIMEOUT   = TX_TIMEOUT
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NSRC-1:0]            src_valid,
  input  logic [NSRC*DW-1:0]         src_data,
  output logic [NSRC-1:0]            src_ready,
  output logic                       m_valid,
  output logic [DW-1:0]              m_data,
  input  logic                       m_ready,
  output logic [tx_width(NSRC)-1:0]  m_src,
  output logic                       burst_done,
  output logic                       burst_abort
);

  localparam int SW = tx_width(NSRC);
  localparam int BW = tx_width(BURST_LEN + 1);
  localparam int TW = tx_width(TIMEOUT + 1);

  tx_state_e     state, state_nx;
  logic [SW-1:0] grant_id, grant_nx;
  logic [SW-1:0] rr_ptr, rr_nx;
  logic [BW-1:0] beat_cnt, beat_nx;
  logic [TW-1:0] idle_cnt, idle_nx;
  logic          done_nx, abort_nx;

  logic [SW-1:0] winner;
  logic          found;
  logic          space;
  logic          g_valid;
  logic [DW-1:0] g_data;
  logic          accept;

  rr_pick #(.N(NSRC), .IW(SW)) u_rr_pick (
    .req    (src_valid),
    .ptr    (rr_ptr),
    .winner (winner),
    .found  (found)
  );

  assign space  = ~m_valid | m_ready;
  assign accept = (state == BURST) & space & g_valid;

  // Constant-index lane select keeps unused lanes out of the datapath.
  always_comb begin
    g_valid   = 1'b0;
    g_data    = '0;
    src_ready = '0;
    for (int i = 0; i < NSRC; i++) begin
      if (grant_id == SW'(i)) begin
        g_valid      = src_valid[i];
        g_data       = src_data[i*DW +: DW];
        src_ready[i] = (state == BURST) & space;
      end
    end
  end

  always_comb begin
    state_nx = state;
    grant_nx = grant_id;
    rr_nx    = rr_ptr;
    beat_nx  = beat_cnt;
    idle_nx  = idle_cnt;
    done_nx  = 1'b0;
    abort_nx = 1'b0;
    case (state)
      IDLE: begin
        if (found) begin
          grant_nx = winner;
          rr_nx    = (winner == SW'(NSRC - 1)) ? '0 : winner + 1'b1;
          beat_nx  = '0;
          idle_nx  = '0;
          state_nx = BURST;
        end
      end
      BURST: begin
        if (accept) begin
          idle_nx = '0;
          if (beat_cnt == BW'(BURST_LEN - 1)) begin
            done_nx  = 1'b1;
            beat_nx  = '0;
            state_nx = IDLE;
          end else begin
            beat_nx = beat_cnt + 1'b1;
          end
        end else if (space) begin
          // Only a source gap with room downstream counts toward the timeout.
          if (idle_cnt == TW'(TIMEOUT - 1)) begin
            abort_nx = 1'b1;
            beat_nx  = '0;
            idle_nx  = '0;
            state_nx = IDLE;
          end else begin
            idle_nx = idle_cnt + 1'b1;
          end
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      grant_id    <= '0;
      rr_ptr      <= '0;
      beat_cnt    <= '0;
      idle_cnt    <= '0;
      burst_done  <= 1'b0;
      burst_abort <= 1'b0;
    end else begin
      state       <= state_nx;
      grant_id    <= grant_nx;
      rr_ptr      <= rr_nx;
      beat_cnt    <= beat_nx;
      idle_cnt    <= idle_nx;
      burst_done  <= done_nx;
      burst_abort <= abort_nx;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid <= 1'b0;
      m_data  <= '0;
      m_src   <= '0;
    end else if (accept) begin
      m_valid <= 1'b1;
      m_data  <= g_data;
      m_src   <= grant_id;
    end else if (m_ready) begin
      m_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_tx_burst_arbiter.sv
// Self-checking bench for tx_burst_arbiter: cycle table for a single burst,
// scoreboard-checked sequences for round-robin, stall, timeout, async reset and NSRC=4 wrap.
module tb_tx_burst_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  src_valid;
  logic [63:0] src_data;
  logic [1:0]  src_ready;
  logic        m_valid;
  logic [31:0] m_data;
  logic        m_ready;
  logic        m_src;
  logic        burst_done;
  logic        burst_abort;

  logic [3:0]   src_valid4;
  logic [127:0] src_data4;
  logic [3:0]   src_ready4;
  logic         m_valid4;
  logic [31:0]  m_data4;
  logic         m_ready4;
  logic [1:0]   m_src4;
  logic         burst_done4;
  logic         burst_abort4;

  always #5 clk = ~clk;

  tx_burst_arbiter #(.NSRC(2), .DW(32), .BURST_LEN(7), .TIMEOUT(16)) u_dut (
    .clk(clk), .rst_n(rst_n), .src_valid(src_valid), .src_data(src_data),
    .src_ready(src_ready), .m_valid(m_valid), .m_data(m_data), .m_ready(m_ready),
    .m_src(m_src), .burst_done(burst_done), .burst_abort(burst_abort)
  );

  tx_burst_arbiter #(.NSRC(4), .DW(32), .BURST_LEN(2), .TIMEOUT(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .src_valid(src_valid4), .src_data(src_data4),
    .src_ready(src_ready4), .m_valid(m_valid4), .m_data(m_data4), .m_ready(m_ready4),
    .m_src(m_src4), .burst_done(burst_done4), .burst_abort(burst_abort4)
  );

  typedef struct {
    int          src;
    logic [31:0] data;
  } beat_t;

  typedef struct {
    logic [1:0]  sv;
    logic        mr;
    logic        mv;
    logic [31:0] md;
    logic [1:0]  rdy;
    logic        done;
  } vec_t;

  beat_t       exp_q[$];
  logic [31:0] seen4[$];
  logic [1:0]  seen_src4[$];
  int          cnt[2];
  logic [3:0]  sv4_next;
  bit          sb_en;
  int          n_tests, n_fail;
  int          done_cnt, abort_cnt, both_cnt, done4_cnt, abort4_cnt;
  vec_t        tbl[10];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] beat_data(input int s, input int n);
    return {8'(s), 24'(n)};
  endfunction

  task automatic push_beats(input int s, input int first, input int last);
    beat_t b;
    for (int n = first; n <= last; n++) begin
      b.src  = s;
      b.data = beat_data(s, n);
      exp_q.push_back(b);
    end
  endtask

  task automatic drive(input logic [1:0] sv, input logic mr);
    @(negedge clk);
    src_valid  = sv;
    m_ready    = mr;
    src_valid4 = sv4_next;
    for (int i = 0; i < 2; i++) src_data[i*32 +: 32] = beat_data(i, cnt[i] + 1);
    #1;
  endtask

  task automatic observe();
    beat_t e;
    if (sb_en && m_valid && m_ready) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL sb_unexpected_beat: actual src %0d data %0h, required no beat", m_src, m_data);
      end else begin
        e = exp_q.pop_front();
        chk("sb_data", 64'(m_data), 64'(e.data));
        chk("sb_src", 64'(m_src), 64'(e.src));
      end
    end
    if (m_valid4 && m_ready4) begin
      seen4.push_back(m_data4);
      seen_src4.push_back(m_src4);
    end
    done_cnt   += int'(burst_done);
    abort_cnt  += int'(burst_abort);
    done4_cnt  += int'(burst_done4);
    abort4_cnt += int'(burst_abort4);
    if (burst_done && burst_abort) both_cnt++;
  endtask

  task automatic advance();
    logic [1:0] acc;
    acc = src_valid & src_ready;
    @(posedge clk);
    for (int i = 0; i < 2; i++) if (acc[i]) cnt[i]++;
  endtask

  task automatic cyc(input logic [1:0] sv, input logic mr);
    drive(sv, mr);
    observe();
    advance();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    src_valid = '0; m_ready = 1'b0; sv4_next = '0; src_valid4 = '0;
    cnt[0] = 0; cnt[1] = 0;
    exp_q.delete(); seen4.delete(); seen_src4.delete();
    done_cnt = 0; abort_cnt = 0; both_cnt = 0; done4_cnt = 0; abort4_cnt = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic end_checks(input string tag, input int exp_done, input int exp_abort);
    chk({tag, "_queue_left"}, 64'(exp_q.size()), 64'd0);
    chk({tag, "_done_count"}, 64'(done_cnt), 64'(exp_done));
    chk({tag, "_abort_count"}, 64'(abort_cnt), 64'(exp_abort));
    chk({tag, "_done_abort_overlap"}, 64'(both_cnt), 64'd0);
  endtask

  initial begin
    n_tests = 0; n_fail = 0; sb_en = 1'b0;
    m_ready4 = 1'b1;
    for (int i = 0; i < 4; i++) src_data4[i*32 +: 32] = {8'(i), 24'h0};

    // cycle table for one burst from source 0 (row = inputs and outputs seen that cycle)
    tbl[0] = '{2'b01, 1'b1, 1'b0, 32'd0, 2'b00, 1'b0};
    tbl[1] = '{2'b01, 1'b1, 1'b0, 32'd0, 2'b01, 1'b0};
    tbl[2] = '{2'b01, 1'b1, 1'b1, 32'd1, 2'b01, 1'b0};
    tbl[3] = '{2'b01, 1'b1, 1'b1, 32'd2, 2'b01, 1'b0};
    tbl[4] = '{2'b01, 1'b1, 1'b1, 32'd3, 2'b01, 1'b0};
    tbl[5] = '{2'b01, 1'b1, 1'b1, 32'd4, 2'b01, 1'b0};
    tbl[6] = '{2'b01, 1'b1, 1'b1, 32'd5, 2'b01, 1'b0};
    tbl[7] = '{2'b01, 1'b1, 1'b1, 32'd6, 2'b01, 1'b0};
    tbl[8] = '{2'b00, 1'b1, 1'b1, 32'd7, 2'b00, 1'b1};
    tbl[9] = '{2'b00, 1'b1, 1'b0, 32'd0, 2'b00, 1'b0};

    rst_n = 1'b0; src_valid = '0; m_ready = 1'b0; sv4_next = '0; src_valid4 = '0; src_data = '0;
    cnt[0] = 0; cnt[1] = 0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_m_valid", 64'(m_valid), 64'd0);
    chk("rst_m_data", 64'(m_data), 64'd0);
    chk("rst_m_src", 64'(m_src), 64'd0);
    chk("rst_burst_done", 64'(burst_done), 64'd0);
    chk("rst_burst_abort", 64'(burst_abort), 64'd0);
    chk("rst_src_ready", 64'(src_ready), 64'd0);
    chk("rst_m_valid4", 64'(m_valid4), 64'd0);

    do_reset();
    for (int r = 0; r < 10; r++) begin
      drive(tbl[r].sv, tbl[r].mr);
      chk($sformatf("tbl%0d_m_valid", r), 64'(m_valid), 64'(tbl[r].mv));
      chk($sformatf("tbl%0d_src_ready", r), 64'(src_ready), 64'(tbl[r].rdy));
      chk($sformatf("tbl%0d_burst_done", r), 64'(burst_done), 64'(tbl[r].done));
      chk($sformatf("tbl%0d_burst_abort", r), 64'(burst_abort), 64'd0);
      if (tbl[r].mv) begin
        chk($sformatf("tbl%0d_m_data", r), 64'(m_data), 64'(tbl[r].md));
        chk($sformatf("tbl%0d_m_src", r), 64'(m_src), 64'd0);
      end
      advance();
    end

    // both sources busy: src0, src1, src0 with one arbitration gap per burst
    do_reset();
    sb_en = 1'b1;
    push_beats(0, 1, 7); push_beats(1, 1, 7); push_beats(0, 8, 14);
    for (int c = 0; c < 24; c++) cyc(2'b11, 1'b1);
    for (int c = 0; c < 3; c++) cyc(2'b00, 1'b1);
    end_checks("rr", 3, 0);

    // output stall at beat 3, then a long source gap while still stalled
    do_reset();
    push_beats(0, 1, 7);
    for (int c = 0; c < 4; c++) cyc(2'b01, 1'b1);
    for (int c = 0; c < 5; c++) begin
      drive(2'b01, 1'b0);
      chk("stall_m_valid", 64'(m_valid), 64'd1);
      chk("stall_m_data", 64'(m_data), 64'(beat_data(0, 3)));
      chk("stall_src_ready", 64'(src_ready), 64'd0);
      observe(); advance();
    end
    for (int c = 0; c < 18; c++) cyc(2'b00, 1'b0);
    chk("stall_hold_data", 64'(m_data), 64'(beat_data(0, 3)));
    for (int c = 0; c < 4; c++) cyc(2'b01, 1'b1);
    for (int c = 0; c < 3; c++) cyc(2'b00, 1'b1);
    end_checks("stall", 1, 0);

    // source 1 goes quiet after two beats; timeout hands the sink to source 0
    do_reset();
    push_beats(1, 1, 2); push_beats(0, 1, 7);
    for (int c = 0; c < 3; c++) cyc(2'b10, 1'b1);
    for (int c = 0; c < 16; c++) begin
      drive(2'b00, 1'b1);
      chk("to_no_early_abort", 64'(burst_abort), 64'd0);
      observe(); advance();
    end
    drive(2'b01, 1'b1);
    chk("to_abort_pulse", 64'(burst_abort), 64'd1);
    chk("to_abort_no_done", 64'(burst_done), 64'd0);
    observe(); advance();
    for (int c = 0; c < 7; c++) cyc(2'b01, 1'b1);
    for (int c = 0; c < 3; c++) cyc(2'b00, 1'b1);
    end_checks("timeout", 1, 1);

    // async reset with a beat sitting in the output register
    do_reset();
    push_beats(0, 1, 2);
    for (int c = 0; c < 4; c++) cyc(2'b01, 1'b1);
    drive(2'b01, 1'b0);
    chk("ar_pre_m_valid", 64'(m_valid), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("ar_m_valid", 64'(m_valid), 64'd0);
    chk("ar_src_ready", 64'(src_ready), 64'd0);
    chk("ar_burst_done", 64'(burst_done), 64'd0);
    chk("ar_m_src", 64'(m_src), 64'd0);
    advance();
    cyc(2'b11, 1'b1);
    push_beats(0, 4, 10);
    drive(2'b11, 1'b1);
    rst_n = 1'b1;
    observe(); advance();
    for (int c = 0; c < 7; c++) cyc(2'b11, 1'b1);
    for (int c = 0; c < 3; c++) cyc(2'b00, 1'b1);
    end_checks("areset", 1, 0);

    // four sources: 3 alone, then 0 and 3 -> 3, 0 (wrap), 3
    do_reset();
    sv4_next = 4'b1000;
    for (int c = 0; c < 3; c++) cyc(2'b00, 1'b1);
    sv4_next = 4'b1001;
    for (int c = 0; c < 6; c++) cyc(2'b00, 1'b1);
    sv4_next = 4'b0000;
    for (int c = 0; c < 3; c++) cyc(2'b00, 1'b1);
    begin
      int exp4[6];
      exp4 = '{3, 3, 0, 0, 3, 3};
      chk("n4_beat_count", 64'(seen_src4.size()), 64'd6);
      for (int k = 0; k < 6 && k < seen_src4.size(); k++) begin
        chk($sformatf("n4_src%0d", k), 64'(seen_src4[k]), 64'(exp4[k]));
        chk($sformatf("n4_data%0d", k), 64'(seen4[k]), 64'({8'(exp4[k]), 24'h0}));
      end
      chk("n4_done_count", 64'(done4_cnt), 64'd3);
      chk("n4_abort_count", 64'(abort4_cnt), 64'd0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
